// File: rtl/context_spill_unit.sv
// context_spill_unit: buffers the exception-save register stream into a fresh
// 16-byte-aligned stack frame and issues each word as a dcache store using the
// index-then-tag handshake.
// Optional macro CONTEXT_SPILL_STALL_CNT_EN builds a saturating stall counter
// on stall_cycles_o; without it the output is tied to zero.
module context_spill_unit #(
   parameter int XLEN        = 64,
   parameter int INDEX_WIDTH = 12,
   parameter int TAG_WIDTH   = 44,
   parameter int NUM_SPILL   = 16,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic [XLEN-1:0]        sp_i,
   output logic                   busy_o,
   output logic [XLEN-1:0]        frame_sp_o,
   output logic                   done_o,
   input  logic                   spill_valid_i,
   input  logic [XLEN-1:0]        spill_data_i,
   output logic                   spill_ready_o,
   output logic [INDEX_WIDTH-1:0] address_index_o,
   output logic [TAG_WIDTH-1:0]   address_tag_o,
   output logic [XLEN-1:0]        data_wdata_o,
   output logic                   data_req_o,
   output logic                   data_we_o,
   output logic [XLEN/8-1:0]      data_be_o,
   output logic [1:0]             data_size_o,
   output logic                   kill_req_o,
   output logic                   tag_valid_o,
   input  logic                   data_gnt_i,
   output logic [15:0]            stall_cycles_o
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(NUM_SPILL + 1);
   localparam int BS = $clog2(XLEN / 8);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                 state;
   logic [XLEN-1:0]        frame_sp;
   logic [XLEN-1:0]        addr;
   logic [CW-1:0]          acc;
   logic [CW-1:0]          iss;
   logic [XLEN-1:0]        mem [FIFO_DEPTH];
   logic [PW-1:0]          wptr;
   logic [PW-1:0]          rptr;
   logic [PW:0]            cnt;
   logic                   tag_valid;
   logic [TAG_WIDTH-1:0]   tag_q;
   logic                   full;
   logic                   empty;
   logic                   push;
   logic                   pop;
   logic                   start;

   assign start           = start_i & (state == IDLE);
   assign full            = cnt == (PW+1)'(FIFO_DEPTH);
   assign empty           = cnt == '0;
   assign busy_o          = state == RUN;
   assign done_o          = state == DONE;
   assign spill_ready_o   = busy_o & ~full & (acc < CW'(NUM_SPILL));
   assign data_req_o      = busy_o & ~empty;
   assign push            = spill_valid_i & spill_ready_o;
   assign pop             = data_req_o & data_gnt_i;
   assign addr            = frame_sp + (XLEN'(iss) << BS);
   assign address_index_o = addr[INDEX_WIDTH-1:0];
   assign address_tag_o   = tag_q;
   assign tag_valid_o     = tag_valid;
   assign data_wdata_o    = data_req_o ? mem[rptr] : '0;
   assign frame_sp_o      = frame_sp;
   assign data_we_o       = 1'b1;
   assign data_be_o       = '1;
   assign data_size_o     = (XLEN == 64) ? 2'b11 : 2'b10;
   assign kill_req_o      = 1'b0;

   // spill buffer storage; occupancy and pointers live with the FSM
   always_ff @(posedge clk_i) begin
      if (push) mem[wptr] <= spill_data_i;
   end

   // frame FSM, buffer bookkeeping and the tag phase that follows each grant
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         frame_sp  <= '0;
         acc       <= '0;
         iss       <= '0;
         wptr      <= '0;
         rptr      <= '0;
         cnt       <= '0;
         tag_valid <= 1'b0;
         tag_q     <= '0;
      end else begin
         tag_valid <= pop;
         if (pop) begin
            tag_q <= TAG_WIDTH'(addr >> INDEX_WIDTH);
            rptr  <= rptr + PW'(1);
            iss   <= iss + CW'(1);
         end
         if (push) begin
            wptr <= wptr + PW'(1);
            acc  <= acc + CW'(1);
         end
         if (push != pop) cnt <= push ? cnt + (PW+1)'(1) : cnt - (PW+1)'(1);
         case (state)
            IDLE: if (start_i) begin
               state    <= RUN;
               frame_sp <= (sp_i - XLEN'(NUM_SPILL * XLEN / 8)) & ~XLEN'(15);
               acc      <= '0;
               iss      <= '0;
            end
            RUN: if (iss == CW'(NUM_SPILL) && tag_valid) state <= DONE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CONTEXT_SPILL_STALL_CNT_EN
   logic [15:0] stall;

   assign stall_cycles_o = stall;

   // cycles a store waited for grant; saturates and survives past done
   always_ff @(posedge clk_i) begin
      if (rst_i) stall <= '0;
      else if (start) stall <= '0;
      else if (data_req_o && !data_gnt_i && stall != 16'hFFFF) stall <= stall + 16'd1;
   end
`else
   assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_context_spill_unit.sv
// tb_context_spill_unit: table-driven frames plus random frames checked against a
// transaction-level model of the spill unit.
module tb_context_spill_unit;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic [63:0] sp_i = '0;
   logic        busy_o;
   logic [63:0] frame_sp_o;
   logic        done_o;
   logic        spill_valid_i = 1'b0;
   logic [63:0] spill_data_i = '0;
   logic        spill_ready_o;
   logic [11:0] address_index_o;
   logic [43:0] address_tag_o;
   logic [63:0] data_wdata_o;
   logic        data_req_o;
   logic        data_we_o;
   logic [7:0]  data_be_o;
   logic [1:0]  data_size_o;
   logic        kill_req_o;
   logic        tag_valid_o;
   logic        data_gnt_i = 1'b0;
   logic [15:0] stall_cycles_o;

   context_spill_unit dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .sp_i(sp_i),
      .busy_o(busy_o), .frame_sp_o(frame_sp_o), .done_o(done_o),
      .spill_valid_i(spill_valid_i), .spill_data_i(spill_data_i),
      .spill_ready_o(spill_ready_o), .address_index_o(address_index_o),
      .address_tag_o(address_tag_o), .data_wdata_o(data_wdata_o),
      .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
      .data_size_o(data_size_o), .kill_req_o(kill_req_o),
      .tag_valid_o(tag_valid_o), .data_gnt_i(data_gnt_i),
      .stall_cycles_o(stall_cycles_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int fails  = 0;

   logic [63:0] r_idx0, r_tag0, r_idx1;
   int          r_grants, r_span, r_maxocc, r_stall;

   typedef struct {
      logic [63:0] sp;
      logic [63:0] fsp;
      logic [63:0] idx0;
      logic [63:0] tag0;
      logic [63:0] idx1;
      int          gpct;
      int          vpct;
      int          hold;
      int          span;
      int          maxocc;
      int          stall;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One frame: start at sp, feed 16 words (base dbase), random valid/grant.
   // hold forces the first `hold` requesting cycles to see no grant.
   // rst_after >= 0 asserts reset once that many grants have happened.
   task automatic run_frame(input logic [63:0] sp, input int gpct, input int vpct,
                            input int hold, input int rst_after, input logic [63:0] dbase);
      logic [63:0] fsp, a;
      logic [63:0] words[$];
      int acc, gr, stall, first_g, last_g, maxocc;
      bit busy, done, tp, fin, v, g, rdy, req, acc_now, gr_now, dn;
      logic [43:0] texp;
      acc = 0; gr = 0; stall = 0; first_g = -1; last_g = -1; maxocc = 0;
      tp = 0; done = 0; fin = 0; texp = '0;
      @(negedge clk_i);
      chk("idle_busy", 64'(busy_o), 64'd0);
      chk("idle_ready", 64'(spill_ready_o), 64'd0);
      chk("idle_req", 64'(data_req_o), 64'd0);
      chk("idle_done", 64'(done_o), 64'd0);
      spill_valid_i = 1'b1; spill_data_i = 64'hDEAD; data_gnt_i = 1'b1;
      start_i = 1'b1; sp_i = sp;
      @(posedge clk_i);
      fsp = (sp - 64'd128) & ~64'hF;
      busy = 1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk_i);
         rdy = busy && (acc - gr) < 4 && acc < 16;
         req = busy && (acc - gr) > 0;
         a = fsp + 64'(gr) * 64'd8;
         chk("busy", 64'(busy_o), 64'(busy));
         chk("done", 64'(done_o), 64'(done));
         chk("ready", 64'(spill_ready_o), 64'(rdy));
         chk("req", 64'(data_req_o), 64'(req));
         chk("frame_sp", frame_sp_o, fsp);
         chk("tag_valid", 64'(tag_valid_o), 64'(tp));
         if (tp) chk("tag", 64'(address_tag_o), 64'(texp));
         if (req && data_req_o) begin
            chk("index", 64'(address_index_o), 64'(a[11:0]));
            chk("wdata", data_wdata_o, words[gr]);
         end
         if (!busy && !done) begin
            fin = 1;
            break;
         end
         if (rst_after >= 0 && gr == rst_after) begin
            rst_i = 1'b1; start_i = 1'b0; spill_valid_i = 1'b1; data_gnt_i = 1'b1;
            @(posedge clk_i);
            @(negedge clk_i);
            rst_i = 1'b0; spill_valid_i = 1'b0; data_gnt_i = 1'b0;
            chk("rst_busy", 64'(busy_o), 64'd0);
            chk("rst_req", 64'(data_req_o), 64'd0);
            chk("rst_tag_valid", 64'(tag_valid_o), 64'd0);
            chk("rst_done", 64'(done_o), 64'd0);
            @(negedge clk_i);
            chk("rst_no_done", 64'(done_o), 64'd0);
            r_grants = gr;
            return;
         end
         v = $urandom_range(99) < vpct;
         g = (stall < hold) ? 1'b0 : ($urandom_range(99) < gpct);
         start_i = done || ($urandom_range(3) == 0);
         sp_i = '0;
         spill_valid_i = v;
         spill_data_i = dbase + 64'(acc);
         data_gnt_i = g;
         acc_now = v && rdy;
         gr_now = req && g;
         if (req && !g) stall++;
         if ((acc - gr) > maxocc) maxocc = acc - gr;
         dn = busy && tp && gr == 16;
         if (gr_now) begin
            texp = a[55:12];
            if (gr == 0) begin r_idx0 = 64'(a[11:0]); r_tag0 = 64'(texp); end
            if (gr == 1) r_idx1 = 64'(a[11:0]);
            if (first_g < 0) first_g = cyc;
            last_g = cyc;
         end
         @(posedge clk_i);
         if (acc_now) begin words.push_back(dbase + 64'(acc)); acc++; end
         if (gr_now) gr++;
         tp = gr_now;
         busy = busy && !dn;
         done = dn;
      end
      start_i = 1'b0; spill_valid_i = 1'b0; data_gnt_i = 1'b0;
      if (!fin) chk("frame_timeout", 64'd0, 64'd1);
`ifdef CONTEXT_SPILL_STALL_CNT_EN
      chk("stall_cnt", 64'(stall_cycles_o), 64'(stall));
`else
      chk("stall_tied", 64'(stall_cycles_o), 64'd0);
`endif
      r_grants = gr; r_span = last_g - first_g; r_maxocc = maxocc; r_stall = stall;
   endtask

   initial begin
      vecs[0] = '{64'h8000_1000, 64'h8000_0F80, 64'hF80, 64'h80000, 64'hF88, 100, 100, 0, 15, -1, -1};
      vecs[1] = '{64'h8000_1008, 64'h8000_0F80, 64'hF80, 64'h80000, 64'hF88, 100, 100, 0, 15, -1, -1};
      vecs[2] = '{64'h8000_1000, 64'h8000_0F80, 64'hF80, 64'h80000, 64'hF88, 100, 100, 10, -1, 4, 10};
      vecs[3] = '{64'h0000_0040, 64'hFFFF_FFFF_FFFF_FFC0, 64'hFC0, 64'hFFF_FFFF_FFFF, 64'hFC8, 50, 70, 0, -1, -1, -1};
      vecs[4] = '{64'h1234_5678_9ABC_DEF7, 64'h1234_5678_9ABC_DE70, 64'hE70, 64'h345_6789_ABCD, 64'hE78, 30, 40, 0, -1, -1, -1};
      vecs[5] = '{64'h0000_0000_0001_0000, 64'h0000_0000_0000_FF80, 64'hF80, 64'hF, 64'hF88, 70, 90, 3, -1, -1, 3};

      repeat (2) @(negedge clk_i);
      chk("rst_busy0", 64'(busy_o), 64'd0);
      chk("rst_done0", 64'(done_o), 64'd0);
      chk("rst_req0", 64'(data_req_o), 64'd0);
      chk("rst_tv0", 64'(tag_valid_o), 64'd0);
      chk("rst_ready0", 64'(spill_ready_o), 64'd0);
      chk("rst_fsp0", frame_sp_o, 64'd0);
      chk("rst_wdata0", data_wdata_o, 64'd0);
      chk("rst_index0", 64'(address_index_o), 64'd0);
      chk("rst_tag0", 64'(address_tag_o), 64'd0);
      chk("rst_stall0", 64'(stall_cycles_o), 64'd0);
      chk("we", 64'(data_we_o), 64'd1);
      chk("be", 64'(data_be_o), 64'hFF);
      chk("size", 64'(data_size_o), 64'd3);
      chk("kill", 64'(kill_req_o), 64'd0);
      rst_i = 1'b0;

      for (int i = 0; i < 6; i++) begin
         run_frame(vecs[i].sp, vecs[i].gpct, vecs[i].vpct, vecs[i].hold, -1, 64'h100 + 64'(i) * 64'h40);
         chk($sformatf("v%0d_fsp", i), frame_sp_o, vecs[i].fsp);
         chk($sformatf("v%0d_idx0", i), r_idx0, vecs[i].idx0);
         chk($sformatf("v%0d_tag0", i), r_tag0, vecs[i].tag0);
         chk($sformatf("v%0d_idx1", i), r_idx1, vecs[i].idx1);
         chk($sformatf("v%0d_grants", i), 64'(r_grants), 64'd16);
         if (vecs[i].span >= 0) chk($sformatf("v%0d_b2b", i), 64'(r_span), 64'(vecs[i].span));
         if (vecs[i].maxocc >= 0) chk($sformatf("v%0d_fill", i), 64'(r_maxocc), 64'(vecs[i].maxocc));
`ifdef CONTEXT_SPILL_STALL_CNT_EN
         if (vecs[i].stall >= 0) chk($sformatf("v%0d_stall", i), 64'(stall_cycles_o), 64'(vecs[i].stall));
`endif
      end

      run_frame(64'h8000_2000, 100, 100, 0, 5, 64'h500);
      chk("rst_mid_grants", 64'(r_grants), 64'd5);
      run_frame(64'h8000_2000, 100, 100, 0, -1, 64'h600);
      chk("post_rst_grants", 64'(r_grants), 64'd16);
      chk("post_rst_fsp", frame_sp_o, 64'h8000_1F80);

      for (int i = 0; i < 8; i++) begin
         logic [63:0] rsp;
         rsp = {32'($urandom), 32'($urandom)};
         run_frame(rsp, $urandom_range(100, 20), $urandom_range(100, 20), $urandom_range(5), -1, 64'($urandom));
         chk($sformatf("rnd%0d_grants", i), 64'(r_grants), 64'd16);
         chk($sformatf("rnd%0d_fsp", i), frame_sp_o, (rsp - 64'd128) & ~64'hF);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/context_spill_unit.md
Name: context_spill_unit

Overview:
- Downstream consumer of the banked register file's exception save sequence.
- On each exception the banked regfile streams the caller-saved registers (t0-t6, a0-a7, ra; 16 words) to this block. The block allocates a stack frame below the current sp.
- Each word is buffered and issued as a store on a dedicated dcache request port, using the CVA6 index-then-tag handshake.
- The new sp is reported back so the banked regfile can write it to the fresh bank.

Parameters:
- XLEN, 64, data/address width.
- INDEX_WIDTH, 12, dcache address_index width.
- TAG_WIDTH, 44, dcache address_tag width; INDEX_WIDTH+TAG_WIDTH <= XLEN.
- NUM_SPILL, 16, words per frame.
- FIFO_DEPTH, 4, spill buffer entries; power of two, >=2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  pulse: begin a frame; ignored when busy_o=1.
- sp_i  in  XLEN  sp value sampled with start_i.
- busy_o  out  1  frame in progress.
- frame_sp_o  out  XLEN  new sp (frame base).
- done_o  out  1  one-cycle pulse: all stores tagged.
- spill_valid_i  in  1  upstream word valid.
- spill_data_i  in  XLEN  register value, in slot order.
- spill_ready_o  out  1  word accepted when valid&ready.
- address_index_o  out  INDEX_WIDTH  dcache index.
- address_tag_o  out  TAG_WIDTH  dcache tag, tag phase.
- data_wdata_o  out  XLEN  store data.
- data_req_o  out  1  store request.
- data_we_o  out  1  constant 1.
- data_be_o  out  XLEN/8  all ones.
- data_size_o  out  2  2'b11 when XLEN=64, 2'b10 when XLEN=32.
- kill_req_o  out  1  constant 0.
- tag_valid_o  out  1  tag phase strobe.
- data_gnt_i  in  1  dcache grant.
- stall_cycles_o  out  16  see Optional Feature.

Behaviour:
- Reset values: all outputs 0, except data_we_o=1, data_be_o=all ones and data_size_o at its constant. FIFO is emptied and all counters cleared.
- FSM states:
  - IDLE: start_i=1 -> RUN next cycle. Latch frame_sp = (sp_i - NUM_SPILL*XLEN/8) & ~0xF, using a 16-byte ABI alignment and modulo-2^XLEN subtraction.
  - RUN: busy_o=1.
    - accepted counter acc (0..NUM_SPILL) and issued counter iss.
    - spill_ready_o = busy_o & !fifo_full & (acc < NUM_SPILL).
    - A word accepted in cycle n can drive data_req_o no earlier than cycle n+1.
  - Issue rules in RUN:
    - data_req_o = !fifo_empty.
    - address = frame_sp + iss*(XLEN/8).
    - address_index_o = address[INDEX_WIDTH-1:0].
    - data_wdata_o = FIFO head.
    - index, data and req are held stable until data_gnt_i=1.
    - On grant: pop head, iss++. Latch tag = address[INDEX_WIDTH+TAG_WIDTH-1:INDEX_WIDTH].
    - Next cycle: tag_valid_o=1, address_tag_o = latched tag. A new request may be presented in that same cycle, giving back-to-back grants with one store per cycle.
  - RUN -> DONE: iss==NUM_SPILL and the final tag phase has completed.
  - DONE: one cycle, done_o=1, busy_o=0 -> IDLE.
- frame_sp_o holds from the cycle after start until the next accepted start.
- Boundaries:
  - FIFO full: ready=0. Simultaneous push and pop when full is not allowed because ready is already low.
  - Simultaneous push and pop when not full: occupancy unchanged.
  - Words beyond NUM_SPILL are never accepted.
  - spill_valid_i while IDLE: ready=0, data ignored.
  - start_i during RUN or DONE: ignored.
  - start_i in the cycle done_o=1: ignored. Software must re-issue.
  - data_gnt_i while data_req_o=0: ignored.
  - rst_i mid-frame: next cycle IDLE, FIFO empty, req/tag_valid low, no done_o pulse.

Optional Feature:
- Macro CONTEXT_SPILL_STALL_CNT_EN.
- Defined: stall_cycles_o counts cycles with data_req_o=1 & data_gnt_i=0 during a frame. It saturates at 0xFFFF, is cleared on accepted start_i, and holds after done.
- Undefined: stall_cycles_o tied to 0 and no counter logic is built.

Test Plan:
- Basic frame: sp_i=0x8000_1000, start, 16 words 0x100..0x10F, gnt always 1.
  - frame_sp_o=0x8000_0F80.
  - Slot 0 has index 0xF80 and tag 0x80000; slot 15 has index 0xFF8.
  - 16 stores back-to-back, then done_o one cycle after the last tag_valid_o.
- Alignment: sp_i=0x8000_1008.
  - frame_sp_o=0x8000_0F80.
  - Slot 1 address index 0xF88.
- Backpressure: gnt held 0 for 10 cycles.
  - FIFO fills to 4 and spill_ready_o=0.
  - req/index/data stable throughout.
  - With the macro defined, stall_cycles_o=10.
- Overflow: upstream keeps valid=1 after 16 words.
  - 17th word never accepted.
  - Exactly 16 data_req_o grants.
- Reset mid-frame: rst_i after 5 grants.
  - Next cycle busy_o=0, data_req_o=0, tag_valid_o=0, no done_o.
  - A new start then produces a full 16-store frame.
- Ignored inputs:
  - start_i pulsed during RUN with sp_i=0x0: frame_sp_o unchanged.
  - spill_valid_i in IDLE: spill_ready_o=0.
